// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register-file write port between ALU and load writeback.
// Define WB_ARB_FWD_EN to add the fwd_rs1/fwd_rs2 bypass compare ports.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_wd,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_wd,
`ifdef WB_ARB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_rs1,
  input  logic [ADDR_W-1:0] fwd_rs2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              we,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] wd,
  output logic              err,
  output logic [CNT_W-1:0]  conflict_cnt
);
  logic              last_grant;
  logic              acc;
  logic              in_range;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_wd;
  // On contention the requester that did not win last time is served.
  assign req0_ready = !rst && !stall && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = !rst && !stall && req1_valid && (!req0_valid || !last_grant);
  assign acc        = req0_ready || req1_ready;
  assign sel_rd     = req1_ready ? req1_rd : req0_rd;
  assign sel_wd     = req1_ready ? req1_wd : req0_wd;
  assign in_range   = {{(32-ADDR_W){1'b0}}, sel_rd} < NUM_REGS;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we           <= 1'b0;
      rd           <= '0;
      wd           <= '0;
      err          <= 1'b0;
      conflict_cnt <= '0;
      last_grant   <= 1'b1;
    end else begin
      we <= acc && sel_rd != '0 && in_range;
      if (acc) begin
        rd         <= sel_rd;
        wd         <= sel_wd;
        last_grant <= req1_ready;
      end
      if (acc && !in_range) err <= 1'b1;
      if (req0_valid && req1_valid && !stall && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`ifdef WB_ARB_FWD_EN
  assign fwd_hit1 = we && rd == fwd_rs1 && rd != '0;
  assign fwd_hit2 = we && rd == fwd_rs2 && rd != '0;
  assign fwd_data = wd;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table-driven directed checks of arbitration, filtering, statistics and reset.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_rd = '0, req1_rd = '0;
  logic [31:0] req0_wd = '0, req1_wd = '0;
  logic        we, err;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [2:0]  conflict_cnt;
`ifdef WB_ARB_FWD_EN
  logic [4:0]  fwd_rs1 = '0, fwd_rs2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data;
`endif
  int pass_cnt = 0;
  int total_cnt = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(16), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_wd(req0_wd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_wd(req1_wd),
`ifdef WB_ARB_FWD_EN
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data),
`endif
    .we(we), .rd(rd), .wd(wd), .err(err), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] wd0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] wd1;
    logic        stall;
    logic        r0;
    logic        r1;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        err;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] w0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] w1, input logic s);
    req0_valid = v0; req0_rd = r0; req0_wd = w0;
    req1_valid = v1; req1_rd = r1; req1_wd = w1;
    stall = s;
  endtask

  initial begin
    //          v0 rd0  wd0           v1 rd1 wd1      st r0 r1 we rd  wd            err cnt
    tv[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,   0, 1, 0, 1, 5,  32'hDEADBEEF, 0, 0};
    tv[1]  = '{0, 0,  32'h0,        0, 0,  32'h0,   0, 0, 0, 0, 5,  32'hDEADBEEF, 0, 0};
    tv[2]  = '{0, 0,  32'h0,        1, 3,  32'h33,  0, 0, 1, 1, 3,  32'h33,       0, 0};
    tv[3]  = '{1, 1,  32'hA1,       1, 2,  32'hB1,  0, 1, 0, 1, 1,  32'hA1,       0, 1};
    tv[4]  = '{1, 1,  32'hA2,       1, 2,  32'hB1,  0, 0, 1, 1, 2,  32'hB1,       0, 2};
    tv[5]  = '{1, 1,  32'hA2,       1, 2,  32'hB2,  0, 1, 0, 1, 1,  32'hA2,       0, 3};
    tv[6]  = '{1, 1,  32'hA3,       1, 2,  32'hB2,  0, 0, 1, 1, 2,  32'hB2,       0, 4};
    tv[7]  = '{0, 0,  32'h0,        1, 0,  32'h1234,0, 0, 1, 0, 0,  32'h1234,     0, 4};
    tv[8]  = '{1, 20, 32'h55,       0, 0,  32'h0,   0, 1, 0, 0, 20, 32'h55,       1, 4};
    tv[9]  = '{1, 6,  32'h66,       0, 0,  32'h0,   0, 1, 0, 1, 6,  32'h66,       1, 4};
    tv[10] = '{0, 0,  32'h0,        1, 7,  32'h77,  0, 0, 1, 1, 7,  32'h77,       1, 4};
    tv[11] = '{1, 1,  32'hC0,       1, 2,  32'hD0,  1, 0, 0, 0, 7,  32'h77,       1, 4};
    tv[12] = '{1, 1,  32'hC0,       1, 2,  32'hD0,  1, 0, 0, 0, 7,  32'h77,       1, 4};
    tv[13] = '{1, 1,  32'hC0,       1, 2,  32'hD0,  1, 0, 0, 0, 7,  32'h77,       1, 4};
    tv[14] = '{1, 1,  32'hC0,       1, 2,  32'hD0,  0, 1, 0, 1, 1,  32'hC0,       1, 5};
    tv[15] = '{1, 15, 32'hFF,       0, 0,  32'h0,   0, 1, 0, 1, 15, 32'hFF,       1, 5};

    repeat (2) @(negedge clk);
    chk("reset_we", {31'b0, we}, 32'd0);
    chk("reset_rd", {27'b0, rd}, 32'd0);
    chk("reset_wd", wd, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_cnt", {29'b0, conflict_cnt}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tv[i].v0, tv[i].rd0, tv[i].wd0, tv[i].v1, tv[i].rd1, tv[i].wd1, tv[i].stall);
      #1;
      chk($sformatf("v%0d_r0", i), {31'b0, req0_ready}, {31'b0, tv[i].r0});
      chk($sformatf("v%0d_r1", i), {31'b0, req1_ready}, {31'b0, tv[i].r1});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i), {31'b0, we}, {31'b0, tv[i].we});
      chk($sformatf("v%0d_rd", i), {27'b0, rd}, {27'b0, tv[i].rd});
      chk($sformatf("v%0d_wd", i), wd, tv[i].wd);
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, tv[i].err});
      chk($sformatf("v%0d_cnt", i), {29'b0, conflict_cnt}, {29'b0, tv[i].cnt});
    end

    // Out-of-range rd=16 is the first illegal address; err was already sticky.
    @(negedge clk);
    drive(0, 0, 0, 1, 16, 32'h16, 0);
    @(posedge clk); #1;
    chk("rd16_we", {31'b0, we}, 32'd0);
    chk("rd16_err", {31'b0, err}, 32'd1);

    // Conflict counter saturates at 7 with CNT_W=3 (starts at 5 here).
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 1, 32'hE0 + i, 1, 2, 32'hF0 + i, 0);
      @(posedge clk); #1;
    end
    chk("cnt_sat", {29'b0, conflict_cnt}, 32'd7);

    // Mid-operation async reset drops the registered write immediately.
    @(negedge clk);
    drive(1, 9, 32'h99, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("pre_rst_we", {31'b0, we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_ready", {31'b0, req0_ready}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_cnt", {29'b0, conflict_cnt}, 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_we", {31'b0, we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // After reset req0 wins the first conflict again.
    @(negedge clk);
    drive(1, 4, 32'h44, 1, 8, 32'h88, 0);
    #1;
    chk("post_rst_r0", {31'b0, req0_ready}, 32'd1);
    chk("post_rst_r1", {31'b0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_rd", {27'b0, rd}, 32'd4);

`ifdef WB_ARB_FWD_EN
    @(negedge clk);
    drive(1, 7, 32'hCAFE0007, 0, 0, 0, 0);
    fwd_rs1 = 5'd7;
    fwd_rs2 = 5'd3;
    @(posedge clk); #1;
    chk("fwd_hit1", {31'b0, fwd_hit1}, 32'd1);
    chk("fwd_hit2", {31'b0, fwd_hit2}, 32'd0);
    chk("fwd_data", fwd_data, 32'hCAFE0007);
`endif

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we, rd, wd) between two writeback requesters: req0 (ALU result) and req1 (load/memory result).
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered output stage drives the register file write port directly.
- Filters x0 and out-of-range writes, and keeps simple contention statistics.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address.
- NUM_REGS, 16, number of physically implemented registers; addresses >= NUM_REGS are illegal.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- stall  in  1  writeback stall; no request is accepted while high.
- req0_valid  in  1  ALU writeback request.
- req0_ready  out  1  ALU request accepted this cycle.
- req0_rd  in  ADDR_W  ALU destination register.
- req0_wd  in  DATA_W  ALU write data.
- req1_valid  in  1  load writeback request.
- req1_ready  out  1  load request accepted this cycle.
- req1_rd  in  ADDR_W  load destination register.
- req1_wd  in  DATA_W  load write data.
- we  out  1  register file write enable.
- rd  out  ADDR_W  register file write address.
- wd  out  DATA_W  register file write data.
- err  out  1  sticky flag: an out-of-range rd was accepted.
- conflict_cnt  out  CNT_W  count of cycles where both requesters were valid and stall was low.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: we=0, rd=0, wd=0, err=0, conflict_cnt=0. Internal last_grant=1, so req0 wins the first conflict.
- Handshake: readyN is combinational from the valids, stall and last_grant. A transfer occurs when validN && readyN on a rising edge. At most one ready is high per cycle.
- A requester holds valid, rd and wd stable until accepted. The arbiter never depends on ready to produce valid (no combinational loop).
- Arbitration when stall=1: both readys are 0.
- Arbitration when stall=0 and exactly one valid: that requester gets ready=1.
- Arbitration when stall=0 and both valid: grant the requester not equal to last_grant.
- last_grant updates to the granted index on every accepted transfer. It is unchanged when nothing is accepted.
- Output latency: an accepted request appears on we/rd/wd on the cycle after acceptance and holds for exactly one cycle.
- Throughput is one write per cycle; back-to-back accepts produce back-to-back we pulses.
- When no transfer occurs, the next-cycle we=0; rd and wd hold their last values.
- x0 filter: rd==0 is accepted normally, but next-cycle we=0. rd and wd still update.
- Range check: rd>=NUM_REGS and rd!=0 is accepted, next-cycle we=0, and err is set to 1.
- err stays 1 until rst.
- conflict_cnt increments by 1 on each cycle with req0_valid && req1_valid && !stall. It saturates at all-ones and does not wrap.
- Stall interaction: a stall does not cancel a write already registered in the output stage. That write still completes on the cycle after acceptance.
- Reset mid-operation: the registered write is dropped immediately (we=0 asynchronously). Pending requests are not accepted while rst is high.

Optional Feature:
- Macro: WB_ARB_FWD_EN.
- Defined: adds input ports fwd_rs1 and fwd_rs2 (ADDR_W each) and output ports fwd_hit1 and fwd_hit2 (1 each), plus fwd_data (DATA_W).
- fwd_hitN = we && rd==fwd_rsN && rd!=0, combinational from the output stage. fwd_data = wd.
- This lets the read stage bypass the write that lands at the current edge.
- Not defined: these ports do not exist and there is no bypass logic. All other behaviour is identical.

Test Plan:
- Reset, then req0 only with rd=5, wd=0xDEADBEEF → req0_ready=1 in cycle 0; cycle 1 shows we=1, rd=5, wd=0xDEADBEEF; cycle 2 shows we=0.
- Both valid for 4 cycles (req0 rd=1, req1 rd=2, each re-presenting new data after accept) → grants req0, req1, req0, req1; we high all 4 following cycles; conflict_cnt=4.
- req1 with rd=0, wd=0x1234 → req1_ready=1; next cycle we=0; err=0.
- req0 with rd=20 (NUM_REGS=16) → accepted; we stays 0; err=1 and remains 1 after later legal writes until rst.
- stall=1 with both valid for 3 cycles → both readys 0, no we pulse, conflict_cnt unchanged. Then stall=0 → req0 granted first.
- Assert rst for 1 cycle while a write is in the output stage → we drops to 0 immediately; conflict_cnt=0 and err=0 after reset. With WB_ARB_FWD_EN defined: write rd=7, fwd_rs1=7 → fwd_hit1=1 and fwd_data equals the written value in that cycle.
